// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seqdet_pkg;
  localparam int MAX_PAT_W = 64;

  typedef enum logic {IDLE = 1'b0, HUNT = 1'b1} state_t;

  function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

  // Ones in [len-1:0]; callers truncate to their own pattern width.
  function automatic logic [MAX_PAT_W-1:0] win_mask(input int unsigned len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_PAT_W; i++)
      if (i < len) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating match counter; a clear coinciding with a match leaves a count of 1.
module seqdet_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset_i)                   count <= '0;
    else if (clr)                  count <= inc ? CNT_W'(1) : '0;
    else if (inc && (count != '1)) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..PAT_W bits, overlap mode, match counter).
// Optional `SEQDET_MASK_EN adds a don't-care mask_i latched with the config.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             overlap_i,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0] mask_i,
`endif
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic             cnt_clr_i,
  output logic             detected_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cfg_err_o,
  output logic             armed_o
);
  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, hist_q, hist_d, hist_shift, win, care;
  logic [LEN_W-1:0] len_q, fill_q, fill_d, fill_inc;
  logic             ovl_q, shift_en, match, legal, det_q, err_q;

  assign legal = len_legal(32'(len_i), PAT_W);
  assign win   = PAT_W'(win_mask(32'(len_q)));

`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask_q;
  always_ff @(posedge clk) begin
    if (reset_i)         mask_q <= '0;
    else if (cfg_load_i) mask_q <= mask_i;
  end
  assign care = win & ~mask_q;
`else
  assign care = win;
`endif

  // Match is judged on the post-shift history so detected_o lands one cycle after the last bit.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hist_shift = {hist_q[PAT_W-2:0], in_i};
    fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    shift_en   = (state_q == HUNT) && in_valid_i && !cfg_load_i;
    match      = shift_en && (fill_inc >= len_q) && (((hist_shift ^ pat_q) & care) == '0);
    if (cfg_load_i) begin
      state_d = legal ? HUNT : IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= match;
      err_q   <= cfg_load_i && !legal;
      if (cfg_load_i) begin
        pat_q <= pat_i;
        len_q <= len_i;
        ovl_q <= overlap_i;
      end
    end
  end

  seqdet_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_i (reset_i),
    .inc     (match),
    .clr     (cnt_clr_i),
    .count   (match_cnt_o)
  );

  assign detected_o = det_q;
  assign cfg_err_o  = err_q;
  assign armed_o    = (state_q == HUNT);
endmodule
